// File: rtl/lcd_refresh_sequencer_pkg.sv
// rtl/lcd_refresh_sequencer_pkg.sv - HD44780 command codes and sequencer state encoding
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    typedef enum logic [2:0] {
        PWR_WAIT,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        CLEAR,
        ADDR1,
        WR_CHAR,
        ADDR2
    } state_t;

    // Bus byte for command states; data slots take char_in instead.
    function automatic logic [7:0] state_cmd(input state_t s);
        case (s)
            FUNC_SET: return CMD_FUNC_SET;
            DISP_ON:  return CMD_DISP_ON;
            ENTRY:    return CMD_ENTRY;
            CLEAR:    return CMD_CLEAR;
            ADDR1:    return CMD_LINE1;
            ADDR2:    return CMD_LINE2;
            default:  return CHAR_SPACE;
        endcase
    endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_if.sv
// rtl/lcd_refresh_sequencer_if.sv - formatter handshake and LCD pin bundle
interface lcd_refresh_sequencer_if;

    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  char_in,
        output index,
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output lcd_data,
        output init_done,
        output frame_done
    );

    modport slave (
        output char_in,
        input  index,
        input  lcd_e,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_data,
        input  init_done,
        input  frame_done
    );

endinterface

// File: rtl/lcd_refresh_sequencer_slot_timer.sv
// rtl/lcd_refresh_sequencer_slot_timer.sv - per-transaction cycle counter with enable-window decode
module lcd_slot_timer #(
    parameter int SLOT_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic slot_start,
    output logic slot_prelast,
    output logic slot_last,
    output logic e_window
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] LAST    = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] PRELAST = CW'(SLOT_CYCLES - 2);
    localparam logic [CW-1:0] HALF    = CW'(SLOT_CYCLES / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at zero while idle so the first slot starts cleanly on run.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_start   = run && (cnt_q == '0);
    assign slot_prelast = run && (cnt_q == PRELAST);
    assign slot_last    = run && (cnt_q == LAST);
    assign e_window     = run && (cnt_q != '0) && (cnt_q <= HALF);

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// rtl/lcd_refresh_sequencer.sv - HD44780 8-bit init sequence and free-running 16x2 refresh
module lcd_refresh_sequencer
    import lcd_pkg::*;
#(
    parameter int SLOT_CYCLES     = 2000,
    parameter int PWR_WAIT_CYCLES = 750000,
    parameter int CLR_SLOTS       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    lcd_refresh_sequencer_if.master   bus
);

    localparam int PW  = $clog2(PWR_WAIT_CYCLES + 1);
    localparam int CLW = $clog2(CLR_SLOTS + 1);
    localparam logic [PW-1:0]  PWR_LAST = PW'(PWR_WAIT_CYCLES - 1);
    localparam logic [CLW-1:0] CLR_LAST = CLW'(CLR_SLOTS - 1);

    state_t         state_q,      state_d;
    logic [PW-1:0]  pwr_cnt_q,    pwr_cnt_d;
    logic [CLW-1:0] clr_cnt_q,    clr_cnt_d;
    logic [4:0]     index_q,      index_d;
    logic           lcd_e_q,      lcd_e_d;
    logic           lcd_rs_q,     lcd_rs_d;
    logic [7:0]     lcd_data_q,   lcd_data_d;
    logic           init_done_q,  init_done_d;
    logic           frame_done_q, frame_done_d;

    logic run;
    logic slot_start;
    logic slot_prelast;
    logic slot_last;
    logic e_window;

    assign run = (state_q != PWR_WAIT);

    lcd_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .slot_start   (slot_start),
        .slot_prelast (slot_prelast),
        .slot_last    (slot_last),
        .e_window     (e_window)
    );

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        index_d      = index_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        // Clear needs a long execution time, so only its first slot strobes.
        lcd_e_d = e_window && ((state_q != CLEAR) || (clr_cnt_q == '0));

        if (slot_start) begin
            lcd_rs_d   = (state_q == WR_CHAR);
            lcd_data_d = (state_q == WR_CHAR) ? bus.char_in : state_cmd(state_q);
        end

        // Advance one cycle before the slot ends so the formatter's registered
        // output is settled by the next slot's sampling point; 31 wraps to 0.
        if (slot_prelast && (state_q == WR_CHAR)) begin
            index_d = index_q + 1'b1;
        end

        case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    state_d   = FUNC_SET;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            FUNC_SET: if (slot_last) state_d = DISP_ON;
            DISP_ON:  if (slot_last) state_d = ENTRY;
            ENTRY:    if (slot_last) state_d = CLEAR;
            CLEAR: begin
                if (slot_last) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        clr_cnt_d   = '0;
                        init_done_d = 1'b1;
                        state_d     = ADDR1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            ADDR1: if (slot_last) state_d = WR_CHAR;
            WR_CHAR: begin
                // index already holds the next position here: 16 ends line 1,
                // 0 ends line 2.
                if (slot_last) begin
                    if (index_q == 5'd16) begin
                        state_d = ADDR2;
                    end else if (index_q == 5'd0) begin
                        state_d      = ADDR1;
                        frame_done_d = 1'b1;
                    end
                end
            end
            ADDR2: if (slot_last) state_d = WR_CHAR;
            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PWR_WAIT;
            pwr_cnt_q    <= '0;
            clr_cnt_q    <= '0;
            index_q      <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            index_q      <= index_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.index      = index_q;
    assign bus.lcd_e      = lcd_e_q;
    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = lcd_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb/tb_lcd_refresh_sequencer.sv - scoreboard bench for lcd_refresh_sequencer
module tb_lcd_refresh_sequencer;

    localparam int SLOT = 8;
    localparam int PWR  = 20;
    localparam int CLR  = 3;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] idx;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   frames;

    exp_t sb[$];

    lcd_refresh_sequencer_if bus ();

    lcd_refresh_sequencer #(
        .SLOT_CYCLES     (SLOT),
        .PWR_WAIT_CYCLES (PWR),
        .CLR_SLOTS       (CLR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Formatter: one-register ROM returning '0'..'9' cyclically by index.
    always @(posedge clk) bus.char_in <= 8'h30 + 8'(32'(bus.index) % 10);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_e(input logic rs, input logic [7:0] d, input logic [4:0] i);
        exp_t e;
        e.rs   = rs;
        e.data = d;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic push_init();
        push_e(1'b0, 8'h38, 5'd0);
        push_e(1'b0, 8'h0C, 5'd0);
        push_e(1'b0, 8'h06, 5'd0);
        push_e(1'b0, 8'h01, 5'd0);
    endtask

    task automatic push_frame();
        push_e(1'b0, 8'h80, 5'd0);
        for (int i = 0; i < 16; i++) push_e(1'b1, 8'h30 + 8'(i % 10), 5'(i));
        push_e(1'b0, 8'hC0, 5'd16);
        for (int i = 16; i < 32; i++) push_e(1'b1, 8'h30 + 8'(i % 10), 5'(i));
    endtask

    // Bus protocol monitor and scoreboard consumer.
    logic       prev_e, prev_rs, prev_fd;
    logic [7:0] prev_data;
    int         e_width, last_rise, clear_rise, last_fd;
    bit         have_rise, have_fd, last_was_clear;

    initial begin
        exp_t x;
        prev_e = 0; prev_rs = 0; prev_fd = 0; prev_data = 0;
        e_width = 0; last_rise = 0; clear_rise = 0; last_fd = 0;
        have_rise = 0; have_fd = 0; last_was_clear = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_e = 0; prev_fd = 0; e_width = 0;
                have_rise = 0; have_fd = 0; last_was_clear = 0;
            end else begin
                check("rw_low", 32'(bus.lcd_rw), 32'd0);
                if (bus.lcd_e && prev_e) begin
                    check("hold_rs", 32'(bus.lcd_rs), 32'(prev_rs));
                    check("hold_data", 32'(bus.lcd_data), 32'(prev_data));
                end
                if (bus.lcd_e && !prev_e) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        x = sb.pop_front();
                        check("slot_rs", 32'(bus.lcd_rs), 32'(x.rs));
                        check("slot_data", 32'(bus.lcd_data), 32'(x.data));
                        check("slot_index", 32'(bus.index), 32'(x.idx));
                        if (have_rise)
                            check("e_gap", 32'(cyc - last_rise), last_was_clear ? 32'(CLR * SLOT) : 32'(SLOT));
                        last_was_clear = (x.rs == 1'b0) && (x.data == 8'h01);
                        if (last_was_clear) clear_rise = cyc;
                    end
                    last_rise = cyc;
                    have_rise = 1;
                    e_width   = 0;
                end
                if (bus.lcd_e) e_width++;
                if (!bus.lcd_e && prev_e) check("e_width", 32'(e_width), 32'(SLOT / 2));
                if (bus.frame_done) begin
                    check("fd_single", 32'(prev_fd), 32'd0);
                    if (!prev_fd) begin
                        frames++;
                        if (have_fd) check("fd_period", 32'(cyc - last_fd), 32'(34 * SLOT));
                        check("fd_next_line1", (sb.size() > 0) ? 32'(sb[0].data) : 32'hFFFF, 32'h80);
                        last_fd = cyc;
                        have_fd = 1;
                    end
                end
                prev_e    = bus.lcd_e;
                prev_rs   = bus.lcd_rs;
                prev_data = bus.lcd_data;
                prev_fd   = bus.frame_done;
            end
        end
    end

    task automatic pwr_quiet_and_init();
        bit seen;
        int n;
        seen = 0;
        repeat (PWR) begin
            @(negedge clk);
            if (bus.lcd_e) seen = 1;
        end
        check("pwr_wait_quiet", 32'(seen), 32'd0);
        n = 0;
        while (!bus.init_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("init_done_rise", 32'(bus.init_done), 32'd1);
        check("init_done_delay", 32'(cyc - clear_rise), 32'(CLR * SLOT - 2));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_count", 32'(frames), 32'(target));
    endtask

    initial begin
        int n;
        tests  = 0;
        fails  = 0;
        frames = 0;
        rst    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
        check("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
        check("rst_lcd_rw", 32'(bus.lcd_rw), 32'd0);
        check("rst_lcd_data", 32'(bus.lcd_data), 32'h00);
        check("rst_index", 32'(bus.index), 32'd0);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);

        push_init();
        repeat (4) push_frame();
        rst = 1'b1;
        pwr_quiet_and_init();
        wait_frames(3, 3 * 34 * SLOT + 200);
        check("init_done_held", 32'(bus.init_done), 32'd1);

        // Reset while lcd_e is high in a data slot.
        n = 0;
        while (!(bus.lcd_e && bus.lcd_rs) && n < 4 * SLOT) begin
            @(negedge clk);
            n++;
        end
        check("found_data_slot", 32'(bus.lcd_e && bus.lcd_rs), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_lcd_e", 32'(bus.lcd_e), 32'd0);
        check("midrst_lcd_data", 32'(bus.lcd_data), 32'h00);
        check("midrst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
        check("midrst_index", 32'(bus.index), 32'd0);
        check("midrst_init_done", 32'(bus.init_done), 32'd0);

        sb.delete();
        frames = 0;
        repeat (2) @(negedge clk);
        push_init();
        push_frame();
        push_e(1'b0, 8'h80, 5'd0);
        rst = 1'b1;
        pwr_quiet_and_init();
        wait_frames(1, 34 * SLOT + 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
